dvg_fetch: RTL and testbench

- Vector-RAM consumer for the Asteroids core: the other end of the GODVG / vector-RAM path, which today only the CPU writes and the bench dumps.
- On a `go` pulse it walks the display list from word address 0 through a synchronous byte read port.
- It executes control-flow opcodes (JMPL, JSRL, RTSL, HALT) internally.
- It streams drawable commands (VCTR, LABS, SVEC) to a downstream beam/rasteriser over a valid/ready handshake.

---
 rtl/dvg_pkg.sv | 32 +++
 rtl/dvg_stack.sv | 50 +++++
 rtl/dvg_fetch.sv | 227 ++++++++++++++++++++++
 tb/tb_dvg_fetch.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvg_pkg.sv
// Shared definitions for the vector-generator display-list fetcher:
// opcodes, command kinds and the fetch state encoding.
package dvg_pkg;

    localparam logic [3:0] OP_LABS = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hB;
    localparam logic [3:0] OP_JSRL = 4'hC;
    localparam logic [3:0] OP_RTSL = 4'hD;
    localparam logic [3:0] OP_JMPL = 4'hE;
    localparam logic [3:0] OP_SVEC = 4'hF;

    localparam logic [1:0] KIND_VCTR = 2'd0;
    localparam logic [1:0] KIND_LABS = 2'd1;
    localparam logic [1:0] KIND_SVEC = 2'd2;

    // F1C is the capture cycle for the high byte of the second word.
    typedef enum logic [2:0] {
        S_IDLE,
        S_F0L,
        S_F0H,
        S_DEC,
        S_F1L,
        S_F1H,
        S_F1C,
        S_EMIT
    } state_t;

    function automatic logic [11:0] pc_inc(input logic [11:0] pc);
        return pc + 12'd1;
    endfunction

endpackage

// File: rtl/dvg_stack.sv
// Small LIFO of return addresses for JSRL/RTSL; push when full and pop when
// empty are ignored here, the caller flags them as errors.
module dvg_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] sp;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [W-1:0]  mem [DEPTH];

    assign full   = (sp == PW'(DEPTH));
    assign empty  = (sp == '0);
    assign wr_idx = AW'(sp);
    assign rd_idx = AW'(sp - PW'(1));
    assign top    = mem[rd_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PW'(1);
        end else if (pop && !empty) begin
            sp <= sp - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/dvg_fetch.sv
// Display-list walker: fetches 16-bit words from vector RAM, runs control flow
// internally and streams drawable commands. DVG_WATCHDOG_EN adds an instruction limit.
module dvg_fetch
    import dvg_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int MAX_INSNS   = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    output logic        mem_en,
    output logic [12:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_kind,
    output logic [15:0] cmd_w0,
    output logic [15:0] cmd_w1,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    state_t      state;
    state_t      state_next;
    logic [11:0] pc;
    logic [7:0]  lo_byte;
    logic [15:0] word;
    logic [3:0]  op;
    logic        stk_push;
    logic        stk_pop;
    logic        stk_clear;
    logic        stk_full;
    logic        stk_empty;
    logic [11:0] stk_top;
    logic        wd_trip;

    if (MAX_INSNS < 1) begin : g_bad_max
        $error("dvg_fetch: MAX_INSNS must be at least 1");
    end

    // The high byte arrives on mem_data during the capture cycle, so the
    // current word is assembled combinationally there.
    assign word      = {mem_data, lo_byte};
    assign op        = word[15:12];
    assign cmd_valid = (state == S_EMIT);

`ifdef DVG_WATCHDOG_EN
    localparam int CW = $clog2(MAX_INSNS + 1);
    logic [CW-1:0] insn_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            insn_cnt <= '0;
        end else if (state == S_IDLE && go) begin
            insn_cnt <= '0;
        end else if (state == S_DEC) begin
            insn_cnt <= insn_cnt + CW'(1);
        end
    end

    assign wd_trip = (state == S_DEC) && (insn_cnt == CW'(MAX_INSNS - 1));
`else
    assign wd_trip = 1'b0;
`endif

    dvg_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (12)
    ) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc(pc)),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_addr   = '0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_clear  = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    stk_clear  = 1'b1;
                    state_next = S_F0L;
                end
            end
            S_F0L: begin
                mem_en     = 1'b1;
                mem_addr   = {pc, 1'b0};
                state_next = S_F0H;
            end
            S_F0H: begin
                mem_en     = 1'b1;
                mem_addr   = {pc, 1'b1};
                state_next = S_DEC;
            end
            S_DEC: begin
                if (wd_trip) begin
                    state_next = S_IDLE;
                end else begin
                    case (op)
                        OP_HALT: state_next = S_IDLE;
                        OP_JSRL: begin
                            stk_push   = !stk_full;
                            state_next = stk_full ? S_IDLE : S_F0L;
                        end
                        OP_RTSL: begin
                            stk_pop    = !stk_empty;
                            state_next = stk_empty ? S_IDLE : S_F0L;
                        end
                        OP_JMPL: state_next = S_F0L;
                        OP_SVEC: state_next = S_EMIT;
                        default: state_next = S_F1L;
                    endcase
                end
            end
            S_F1L: begin
                mem_en     = 1'b1;
                mem_addr   = {pc, 1'b0};
                state_next = S_F1H;
            end
            S_F1H: begin
                mem_en     = 1'b1;
                mem_addr   = {pc, 1'b1};
                state_next = S_F1C;
            end
            S_F1C: state_next = S_EMIT;
            S_EMIT: begin
                if (cmd_ready) begin
                    state_next = S_F0L;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= '0;
            lo_byte  <= '0;
            cmd_kind <= '0;
            cmd_w0   <= '0;
            cmd_w1   <= '0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        pc     <= '0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                S_F0H, S_F1H: lo_byte <= mem_data;
                S_DEC: begin
                    if (wd_trip) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        case (op)
                            OP_HALT: begin
                                halted <= 1'b1;
                                busy   <= 1'b0;
                            end
                            OP_JSRL: begin
                                if (stk_full) begin
                                    err  <= 1'b1;
                                    busy <= 1'b0;
                                end else begin
                                    pc <= word[11:0];
                                end
                            end
                            OP_RTSL: begin
                                if (stk_empty) begin
                                    err  <= 1'b1;
                                    busy <= 1'b0;
                                end else begin
                                    pc <= stk_top;
                                end
                            end
                            OP_JMPL: pc <= word[11:0];
                            OP_SVEC: begin
                                cmd_kind <= KIND_SVEC;
                                cmd_w0   <= word;
                                cmd_w1   <= '0;
                            end
                            default: begin
                                cmd_kind <= (op == OP_LABS) ? KIND_LABS : KIND_VCTR;
                                cmd_w0   <= word;
                                pc       <= pc_inc(pc);
                            end
                        endcase
                    end
                end
                S_F1C: cmd_w1 <= word;
                S_EMIT: begin
                    if (cmd_ready) begin
                        pc <= pc_inc(pc);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dvg_fetch.sv
// Scoreboarded bench for dvg_fetch: a list-walking reference model predicts the
// command stream and final flags; a monitor checks every accepted command.
module tb_dvg_fetch;

    localparam int DEPTH = 4;
    localparam int MAXI  = 16;
    localparam int LIMIT = 60;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0;
    logic        mem_en;
    logic [12:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_kind;
    logic [15:0] cmd_w0;
    logic [15:0] cmd_w1;
    logic        busy;
    logic        halted;
    logic        err;

    always #5 clk = ~clk;

    dvg_fetch #(
        .STACK_DEPTH (DEPTH),
        .MAX_INSNS   (MAXI)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .go        (go),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_w0    (cmd_w0),
        .cmd_w1    (cmd_w1),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    logic [7:0] ram [0:8191];

    always @(posedge clk) begin
        if (mem_en) mem_data <= ram[mem_addr];
    end

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] w0;
        logic [15:0] w1;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   held = 1'b0;
    cmd_t held_cmd;
    cmd_t exp_cmd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
    endtask

    task automatic set_word(input int a, input logic [15:0] w);
        ram[2*a]   = w[7:0];
        ram[2*a+1] = w[15:8];
    endtask

    function automatic logic [15:0] word_at(input int a);
        return {ram[2*a+1], ram[2*a]};
    endfunction

    // Walks the list from word 0 following the instruction set's rules.
    task automatic model_run(output bit e_halt, output bit e_err, output bit endless);
        int          pc;
        int          n;
        int          stk[$];
        cmd_t        loc[$];
        cmd_t        c;
        logic [15:0] w;
        logic [3:0]  op;
        pc = 0; n = 0;
        e_halt = 0; e_err = 0; endless = 0;
        while (1) begin
            if (n >= LIMIT) begin endless = 1; break; end
            w = word_at(pc);
            n++;
`ifdef DVG_WATCHDOG_EN
            if (n == MAXI) begin e_err = 1; break; end
`endif
            op = w[15:12];
            if (op <= 4'hA) begin
                c.kind = (op == 4'hA) ? 2'd1 : 2'd0;
                c.w0 = w;
                c.w1 = word_at((pc + 1) % 4096);
                loc.push_back(c);
                pc = (pc + 2) % 4096;
            end else if (op == 4'hF) begin
                c.kind = 2'd2; c.w0 = w; c.w1 = 16'h0000;
                loc.push_back(c);
                pc = (pc + 1) % 4096;
            end else if (op == 4'hB) begin
                e_halt = 1; break;
            end else if (op == 4'hC) begin
                if (stk.size() == DEPTH) begin e_err = 1; break; end
                stk.push_back((pc + 1) % 4096);
                pc = int'(w[11:0]);
            end else if (op == 4'hD) begin
                if (stk.size() == 0) begin e_err = 1; break; end
                pc = stk.pop_back();
            end else begin
                pc = int'(w[11:0]);
            end
        end
        if (!endless) foreach (loc[i]) exp_q.push_back(loc[i]);
    endtask

    // Runs one list to completion; bp forces ready low for that many cycles of the first valid command.
    task automatic run_prog(input int pct, input int bp, output bit endless, output int lat);
        bit eh, ee;
        int cyc;
        int bp_left;
        lat = 0;
        model_run(eh, ee, endless);
        if (endless) return;
        bp_left = bp;
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        cyc = 1;
        check("busy_after_go", busy, 1);
        check("halted_cleared_by_go", halted, 0);
        while (busy && cyc < 4000) begin
            if (cmd_valid && lat == 0) lat = cyc;
            if (cmd_valid && bp_left > 0) begin
                cmd_ready = 1'b0;
                bp_left--;
            end else begin
                cmd_ready = ($urandom_range(99) < pct);
            end
            @(posedge clk); #1;
            cyc++;
        end
        cmd_ready = 1'b0;
        check("walk_done_busy", busy, 0);
        check("final_halted", halted, eh);
        check("final_err", err, ee);
        check("cmds_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_cmd_kind"}, cmd_kind, 0);
        check({tag, "_cmd_w0"}, cmd_w0, 0);
        check({tag, "_cmd_w1"}, cmd_w1, 0);
        check({tag, "_flags"}, {busy, halted, err}, 0);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            held = 1'b0;
        end else if (cmd_valid) begin
            check("mem_en_during_emit", mem_en, 0);
            if (held) begin
                check("hold_kind", cmd_kind, held_cmd.kind);
                check("hold_w0", cmd_w0, held_cmd.w0);
                check("hold_w1", cmd_w1, held_cmd.w1);
            end
            if (cmd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got kind %0d w0 %h w1 %h with none expected",
                             cmd_kind, cmd_w0, cmd_w1);
                end else begin
                    exp_cmd = exp_q.pop_front();
                    check("cmd_kind", cmd_kind, exp_cmd.kind);
                    check("cmd_w0", cmd_w0, exp_cmd.w0);
                    check("cmd_w1", cmd_w1, exp_cmd.w1);
                end
            end
            held = !cmd_ready;
            held_cmd = '{kind: cmd_kind, w0: cmd_w0, w1: cmd_w1};
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit endless;
        int lat;
        int drops;
        int tries;
        int r;
        logic [3:0] vop;

        clear_ram();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // SVEC then HALT, with go-to-valid latency
        clear_ram();
        set_word(0, 16'hF000);
        set_word(1, 16'hB000);
        run_prog(100, 0, endless, lat);
        check("svec_latency", lat, 4);

        // VCTR held under backpressure
        clear_ram();
        set_word(0, 16'h6123);
        set_word(1, 16'h4567);
        set_word(2, 16'hB000);
        run_prog(100, 5, endless, lat);

        // Subroutine call and return
        clear_ram();
        set_word(0, 16'hC010);
        set_word(1, 16'hB000);
        set_word(16, 16'hF111);
        set_word(17, 16'hD000);
        run_prog(100, 0, endless, lat);

        // Recursive JSRL overflows the return stack
        clear_ram();
        set_word(0, 16'hC000);
        run_prog(100, 0, endless, lat);

        // JMPL self-loop
        clear_ram();
        set_word(0, 16'hE000);
`ifdef DVG_WATCHDOG_EN
        run_prog(100, 0, endless, lat);
`else
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        drops = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) drops++;
            @(posedge clk); #1;
        end
        check("endless_busy_drops", drops, 0);
        check("endless_no_err", err, 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
`endif

        // Halt, then go clears halted, then reset during F1H
        clear_ram();
        set_word(0, 16'hF000);
        set_word(1, 16'hB000);
        run_prog(100, 0, endless, lat);
        clear_ram();
        set_word(0, 16'h6123);
        set_word(1, 16'h4567);
        set_word(2, 16'hB000);
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        check("go_clears_halted", halted, 0);
        repeat (4) @(posedge clk);
        #1;
        check("f1h_mem_en", mem_en, 1);
        check("f1h_mem_addr", mem_addr, 13'd3);
        check("f1h_cmd_w0", cmd_w0, 16'h6123);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_q.delete();

        // Randomised lists over words 0..15, HALT guard at 16/17
        for (int k = 0; k < 30; k++) begin
            tries = 0;
            do begin
                clear_ram();
                for (int a = 0; a < 16; a++) begin
                    r = $urandom_range(9);
                    vop = 4'($urandom_range(9));
                    case (r)
                        0, 1, 2: set_word(a, {vop, 12'($urandom)});
                        3:       set_word(a, {4'hA, 12'($urandom)});
                        4, 5:    set_word(a, {4'hF, 12'($urandom)});
                        6:       set_word(a, {4'hB, 12'($urandom)});
                        7:       set_word(a, {4'hC, 12'($urandom_range(15))});
                        8:       set_word(a, {4'hD, 12'($urandom)});
                        default: set_word(a, {4'hE, 12'($urandom_range(15))});
                    endcase
                end
                set_word(16, 16'hB000);
                set_word(17, 16'hB000);
                run_prog(70, $urandom_range(3), endless, lat);
                tries++;
            end while (endless && tries < 50);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
